// File: rtl/kyber_ntt_pkg.sv
// Shared encodings for the Kyber NTT datapath: address generator modes,
// transform geometry and the job sequencer state encoding.
package kyber_ntt_pkg;

  localparam int unsigned NUM_LAYERS = 7;
  localparam int unsigned NUM_COEFFS = 256;

  localparam logic [1:0] MODE_NTT  = 2'b00;
  localparam logic [1:0] MODE_INTT = 2'b01;
  localparam logic [1:0] MODE_IN   = 2'b10;
  localparam logic [1:0] MODE_OUT  = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StPrep,
    StRun,
    StNext,
    StStore,
    StDone
  } seq_state_e;

endpackage

// File: rtl/ntt_beat_counter.sv
// Handshake beat counter with synchronous clear and a terminal-count flag that
// fires on the beat that completes the phase.
module ntt_beat_counter #(
  parameter int unsigned CNT_W    = 9,
  parameter int unsigned TERMINAL = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic last
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last = inc && (count_q == CNT_W'(TERMINAL - 1));

endmodule

// File: rtl/ntt_seq_ctrl.sv
// Job sequencer for one Kyber transform: load coefficients, step the address
// generator through every butterfly layer, then stream the results out.
module ntt_seq_ctrl #(
  parameter int unsigned NUM_LAYERS = kyber_ntt_pkg::NUM_LAYERS,
  parameter int unsigned NUM_COEFFS = kyber_ntt_pkg::NUM_COEFFS,
  parameter int unsigned LAYER_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               op_intt,
  input  logic               abort,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic               st_ready,
  output logic               st_valid,
  input  logic               ag_done,
  output logic [1:0]         ag_mode,
  output logic               ag_newloop,
  output logic [LAYER_W-1:0] layer,
  output logic [6:0]         zeta_base,
  output logic               busy,
  output logic               done
);

  import kyber_ntt_pkg::*;

  localparam logic [LAYER_W-1:0] LastLayer = LAYER_W'(NUM_LAYERS - 1);

  seq_state_e         state_q, state_d;
  logic               op_q, op_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [6:0]         zeta_q, zeta_d;
  logic               beat_clear, beat_inc, beat_last;

  // Forward transform walks twiddle bases upward, inverse walks them downward.
  function automatic logic [6:0] zeta_of(input logic intt, input logic [LAYER_W-1:0] l);
    logic [LAYER_W-1:0] sh;
    sh = intt ? (LastLayer - l) : l;
    return 7'(1) << sh;
  endfunction

  assign beat_inc   = ((state_q == StLoad) && ld_valid) || ((state_q == StStore) && st_ready);
  assign beat_clear = abort || (state_q == StIdle) || (state_q == StNext);

  ntt_beat_counter #(
    .CNT_W    (9),
    .TERMINAL (NUM_COEFFS)
  ) u_beat_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (beat_clear),
    .inc   (beat_inc),
    .last  (beat_last)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    layer_d = layer_q;
    zeta_d  = zeta_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          op_d    = op_intt;
          layer_d = '0;
          zeta_d  = zeta_of(op_intt, '0);
          state_d = StLoad;
        end
      end
      StLoad:  if (beat_last) state_d = StPrep;
      StPrep:  state_d = StRun;
      StRun:   if (ag_done) state_d = StNext;
      StNext: begin
        if (layer_q == LastLayer) begin
          state_d = StStore;
        end else begin
          layer_d = layer_q + LAYER_W'(1);
          zeta_d  = zeta_of(op_q, layer_q + LAYER_W'(1));
          state_d = StPrep;
        end
      end
      StStore: if (beat_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort) begin
      state_d = StIdle;
      layer_d = '0;
      zeta_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= 1'b0;
      layer_q <= '0;
      zeta_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      layer_q <= layer_d;
      zeta_q  <= zeta_d;
    end
  end

  // Handshake and mode outputs depend only on registered state.
  always_comb begin
    ld_ready   = 1'b0;
    st_valid   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    ag_newloop = 1'b0;
    ag_mode    = op_q ? MODE_INTT : MODE_NTT;
    case (state_q)
      StIdle: begin
        busy       = 1'b0;
        ag_newloop = 1'b1;
        ag_mode    = MODE_IN;
      end
      StLoad: begin
        ld_ready = 1'b1;
        ag_mode  = MODE_IN;
      end
      StPrep:  ag_newloop = 1'b1;
      StRun, StNext: begin
      end
      StStore: begin
        st_valid = 1'b1;
        ag_mode  = MODE_OUT;
      end
      StDone: begin
        done       = 1'b1;
        ag_newloop = 1'b1;
        ag_mode    = MODE_IN;
      end
      default: begin
        busy       = 1'b0;
        ag_newloop = 1'b1;
        ag_mode    = MODE_IN;
      end
    endcase
  end

  assign layer     = layer_q;
  assign zeta_base = zeta_q;

endmodule

// File: tb/tb_ntt_seq_ctrl.sv
// Self-checking bench for ntt_seq_ctrl: table of transform jobs plus abort and
// asynchronous-reset sequences, with a queue of expected per-layer setups.
module tb_ntt_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_req = 1'b0, ghost_start = 1'b0;
  logic       op_intt = 1'b0, abort = 1'b0;
  logic       ld_valid = 1'b0, st_ready = 1'b0;
  logic       force_done = 1'b0, stub_done;
  logic       ld_ready, st_valid, ag_newloop, busy, done;
  logic [1:0] ag_mode;
  logic [2:0] layer;
  logic [6:0] zeta_base;

  ntt_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start_req | ghost_start),
    .op_intt    (op_intt),
    .abort      (abort),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .st_ready   (st_ready),
    .st_valid   (st_valid),
    .ag_done    (stub_done | force_done),
    .ag_mode    (ag_mode),
    .ag_newloop (ag_newloop),
    .layer      (layer),
    .zeta_base  (zeta_base),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Address generator stub: layer-complete flag rises 5 cycles after newloop drops.
  int agc = 0;
  always @(posedge clk) begin
    if (ag_newloop) agc <= 0;
    else if (agc < 7) agc <= agc + 1;
  end
  assign stub_done = (agc >= 5);

  // Per-job stimulus knobs.
  logic ld_tog = 1'b0, st_burst = 1'b0, ghost = 1'b0, cur_op = 1'b0;
  int   cyc = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      ld_valid    = ld_tog ? cyc[0] : 1'b1;
      st_ready    = st_burst ? ((cyc % 20) >= 10) : 1'b1;
      ghost_start = ghost && ((cyc % 5) == 0) &&
                    (ld_ready || (busy && !ag_newloop && !ld_ready && !st_valid));
      force_done  = ghost && ld_ready;
    end
  end

  typedef struct packed {
    logic [2:0] layer;
    logic [6:0] zeta;
    logic [1:0] mode;
  } prep_t;

  prep_t      prep_q[$];
  int         ld_beats, st_beats, done_cnt, prep_seen, mode_err;
  logic [6:0] first_zeta, last_zeta;

  always @(negedge clk) begin
    if (!rst) begin
      if (ld_valid && ld_ready) ld_beats++;
      if (st_valid && st_ready) st_beats++;
      if (done) done_cnt++;
      if (ld_ready && (ag_mode != 2'b10 || st_valid)) mode_err++;
      if (st_valid && ag_mode != 2'b11) mode_err++;
      if (busy && !ag_newloop && !ld_ready && !st_valid && ag_mode != {1'b0, cur_op}) mode_err++;
      if (ag_newloop && busy && !done) begin
        prep_t e;
        if (prep_q.size() == 0) begin
          check("prep_unexpected", 32'(layer), 32'hffff);
        end else begin
          e = prep_q.pop_front();
          check("prep_layer", 32'(layer), 32'(e.layer));
          check("prep_zeta", 32'(zeta_base), 32'(e.zeta));
          check("prep_mode", 32'(ag_mode), 32'(e.mode));
        end
        if (prep_seen == 0) first_zeta = zeta_base;
        last_zeta = zeta_base;
        prep_seen++;
      end
    end
  end

  task automatic clear_stats();
    ld_beats = 0; st_beats = 0; done_cnt = 0; prep_seen = 0; mode_err = 0;
    first_zeta = '0; last_zeta = '0;
  endtask

  task automatic launch(input logic op, input int n_layers);
    @(negedge clk);
    clear_stats();
    cur_op = op;
    for (int l = 0; l < n_layers; l++) begin
      prep_t e;
      e.layer = 3'(l);
      e.zeta  = op ? (7'd64 >> l) : (7'd1 << l);
      e.mode  = op ? 2'b01 : 2'b00;
      prep_q.push_back(e);
    end
    op_intt   = op;
    start_req = 1'b1;
    @(posedge clk);
    #1 start_req = 1'b0;
  endtask

  task automatic wait_done(input int bound, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
  endtask

  typedef struct {
    logic       op;
    logic       ld_tog;
    logic       st_burst;
    logic       ghost;
    logic [6:0] exp_z_first;
    logic [6:0] exp_z_last;
    int         exp_beats;
  } job_t;

  job_t jobs[4];
  logic seen;
  localparam logic [16:0] ResetVec = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'd0, 7'd0};

  function automatic logic [16:0] out_vec();
    return {ld_ready, st_valid, busy, done, ag_newloop, ag_mode, layer, zeta_base};
  endfunction

  initial begin
    jobs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'd1,  7'd64, 256};
    jobs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'd64, 7'd1,  256};
    jobs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 7'd1,  7'd64, 256};
    jobs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 7'd64, 7'd1,  256};
    clear_stats();

    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(out_vec()), 32'(ResetVec));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_outputs", 32'(out_vec()), 32'(ResetVec));

    foreach (jobs[j]) begin
      ld_tog = jobs[j].ld_tog; st_burst = jobs[j].st_burst; ghost = jobs[j].ghost;
      launch(jobs[j].op, 7);
      wait_done(20000, seen);
      check("job_done_seen", 32'(seen), 32'd1);
      @(negedge clk);
      check("busy_after_done", 32'({busy, done}), 32'd0);
      ghost = 1'b0;
      repeat (3) @(negedge clk);
      check("ld_beats", 32'(ld_beats), 32'(jobs[j].exp_beats));
      check("st_beats", 32'(st_beats), 32'(jobs[j].exp_beats));
      check("done_pulses", 32'(done_cnt), 32'd1);
      check("prep_count", 32'(prep_seen), 32'd7);
      check("zeta_first", 32'(first_zeta), 32'(jobs[j].exp_z_first));
      check("zeta_last", 32'(last_zeta), 32'(jobs[j].exp_z_last));
      check("mode_errors", 32'(mode_err), 32'd0);
      prep_q.delete();
    end

    // Abort in RUN at layer 3.
    ld_tog = 1'b0; st_burst = 1'b0;
    launch(1'b0, 4);
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      if (busy && !ag_newloop && !ld_ready && !st_valid && layer == 3'd3) seen = 1'b1;
    end
    check("reached_run_l3", 32'(seen), 32'd1);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort_outputs", 32'(out_vec()), 32'(ResetVec));
    repeat (20) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_preps", 32'(prep_q.size()), 32'd0);
    prep_q.delete();
    launch(1'b0, 7);
    wait_done(20000, seen);
    check("post_abort_done", 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    check("post_abort_prep", 32'(prep_seen), 32'd7);
    check("post_abort_st", 32'(st_beats), 32'd256);

    // Asynchronous reset mid-STORE.
    launch(1'b1, 7);
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      if (st_valid && st_beats > 30) seen = 1'b1;
    end
    check("reached_store", 32'(seen), 32'd1);
    #2 rst = 1'b1;
    #1 check("async_reset", 32'(out_vec()), 32'(ResetVec));
    @(negedge clk);
    rst = 1'b0;
    prep_q.delete();
    @(negedge clk);
    check("after_reset_idle", 32'(out_vec()), 32'(ResetVec));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
